// File: rtl/saw_tx_sequencer_if.sv
// Bundle of the packet-source, link-framer and ACK signals of one
// stop-and-wait transmit channel, plus the channel status outputs.
//
// Handshake rule for both pkt_* and frm_*: a transfer happens on a rising
// clk edge where valid and ready are both high. Once the sender raises
// valid it keeps valid and its data stable until that transfer. The
// receiver may raise or drop ready at any time. ack_valid is a one-cycle
// strobe with no ready; it is sampled every cycle.
interface saw_tx_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int RTY_W  = 3
);
  // network layer -> sequencer
  logic              pkt_valid;
  logic [DATA_W-1:0] pkt_data;
  logic              pkt_ready;
  // sequencer -> link framer
  logic              frm_valid;
  logic [DATA_W-1:0] frm_data;
  logic              frm_seq;
  logic              frm_ready;
  // link receiver -> sequencer
  logic              ack_valid;
  logic              ack_seq;
  logic              ack_err;
  // channel status
  logic              tx_done;
  logic              tx_fail;
  logic              busy;
  logic [RTY_W-1:0]  retry_cnt;

  // sequencer side
  modport master (
    input  pkt_valid, pkt_data, frm_ready, ack_valid, ack_seq, ack_err,
    output pkt_ready, frm_valid, frm_data, frm_seq,
    output tx_done, tx_fail, busy, retry_cnt
  );

  // environment side (packet source, framer, ACK receiver)
  modport slave (
    output pkt_valid, pkt_data, frm_ready, ack_valid, ack_seq, ack_err,
    input  pkt_ready, frm_valid, frm_data, frm_seq,
    input  tx_done, tx_fail, busy, retry_cnt
  );
endinterface

// File: rtl/saw_tx_sequencer.sv
// Stop-and-wait ARQ transmit sequencer. Accepts one packet at a time,
// stores it with a 1-bit sequence number, sends it to the framer, then
// waits for a matching ACK. A missing ACK triggers a resend of the same
// copy; after MAX_RETRY resends the packet is abandoned with tx_fail.
module saw_tx_sequencer #(
  parameter int DATA_W    = 8,
  parameter int TIMEOUT   = 16,
  parameter int TMR_W     = 8,
  parameter int MAX_RETRY = 4,
  parameter int RTY_W     = 3
) (
  input  logic                 clk,
  input  logic                 rstn,
  saw_tx_sequencer_if.master   bus,
  output logic [1:0]           dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  // Timer is loaded with TIMEOUT-1 and the timeout fires on the cycle it
  // reads zero, so WAIT lasts exactly TIMEOUT cycles per send.
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  logic [1:0]        state_q, state_d;
  logic              seq_q, seq_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [RTY_W-1:0]  retry_q, retry_d;
  logic [DATA_W-1:0] copy_q, copy_d;
  logic              done_q, done_d;
  logic              fail_q, fail_d;

  logic pkt_fire;
  logic frm_fire;
  logic good_ack;
  logic timed_out;
  logic retries_spent;

  // Handshake and ACK qualification terms used by the next-state logic.
  always_comb begin
    pkt_fire      = bus.pkt_valid & bus.pkt_ready;
    frm_fire      = bus.frm_valid & bus.frm_ready;
    good_ack      = bus.ack_valid & ~bus.ack_err & (bus.ack_seq == seq_q);
    timed_out     = (timer_q == '0);
    retries_spent = (retry_q == RTY_MAX);
  end

  // Next-state and datapath updates; good ACK outranks the timeout.
  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    timer_d = timer_q;
    retry_d = retry_q;
    copy_d  = copy_q;
    done_d  = 1'b0;
    fail_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pkt_fire) begin
          copy_d  = bus.pkt_data;
          retry_d = '0;
          state_d = ST_SEND;
        end
      end

      ST_SEND: begin
        // No timer here: the framer may stall us for as long as it likes.
        if (frm_fire) begin
          timer_d = TMR_LOAD;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (good_ack) begin
          seq_d   = ~seq_q;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (timed_out) begin
          if (retries_spent) begin
            fail_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = ST_SEND;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      seq_q   <= 1'b0;
      timer_q <= '0;
      retry_q <= '0;
      copy_q  <= '0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      copy_q  <= copy_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
    end
  end

  // Outputs decode directly from state and the stored copy.
  always_comb begin
    // pkt_ready is gated by rstn so no packet is taken while reset is held.
    bus.pkt_ready = (state_q == ST_IDLE) & rstn;
    bus.frm_valid = (state_q == ST_SEND);
    bus.frm_data  = copy_q;
    bus.frm_seq   = seq_q;
    bus.busy      = (state_q == ST_SEND) | (state_q == ST_WAIT);
    bus.tx_done   = done_q;
    bus.tx_fail   = fail_q;
    bus.retry_cnt = retry_q;
    dbg_state     = state_q;
  end

endmodule

// File: tb/tb_saw_tx_sequencer.sv
// Bench for saw_tx_sequencer: directed table of packet plans, a reset
// sequence mid-WAIT, then randomized plans whose outcome is predicted by a
// transaction-level model. A monitor checks every frame handshake against
// an expected queue.
module tb_saw_tx_sequencer;
  localparam int DATA_W    = 8;
  localparam int TIMEOUT   = 16;
  localparam int TMR_W     = 8;
  localparam int MAX_RETRY = 2;
  localparam int RTY_W     = 3;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rstn;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  saw_tx_sequencer_if #(.DATA_W(DATA_W), .RTY_W(RTY_W)) bus ();

  saw_tx_sequencer #(
    .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .TMR_W(TMR_W),
    .MAX_RETRY(MAX_RETRY), .RTY_W(RTY_W)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;
  bit m_seq;
  logic [DATA_W:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    int         bp;
    int         a0;
    int         a1;
    int         a2;
    bit         bad;
    int         exp_sends;
    bit         exp_done;
    string      name;
  } vec_t;

  vec_t vt[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard: frame handshakes ----------------
  logic [DATA_W:0] got_frm;
  always @(negedge clk) begin
    if (rstn && bus.frm_valid && bus.frm_ready) begin
      got_frm = {bus.frm_seq, bus.frm_data};
      if (exp_q.size() == 0) begin
        check("frame_unexpected", 32'(got_frm), 32'h1ff);
      end else begin
        check("frame_seq_data", 32'(got_frm), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver ----------------
  // One packet: accept it, then for each send apply backpressure, hand the
  // frame over and either ACK at WAIT cycle ack_at[s] or let it time out.
  task automatic run_packet(input logic [7:0] data, input int bp,
                            input int a0, input int a1, input int a2,
                            input bit bad, input int exp_sends,
                            input bit exp_done, input string tag);
    int ack_at[3];
    bit acked;
    int kind;
    ack_at[0] = a0;
    ack_at[1] = a1;
    ack_at[2] = a2;
    acked = 1'b0;

    check({tag, "_pkt_ready"}, 32'(bus.pkt_ready), 32'd1);
    bus.pkt_valid = 1'b1;
    bus.pkt_data  = data;
    step();
    bus.pkt_valid = 1'b0;
    bus.pkt_data  = 8'($urandom);

    for (int s = 0; s <= MAX_RETRY && !acked; s++) begin
      check({tag, "_send_vbr"}, 32'({bus.frm_valid, bus.busy, bus.pkt_ready}), 32'b110);
      check({tag, "_send_retry"}, 32'(bus.retry_cnt), 32'(s));
      check({tag, "_send_pulses"}, 32'({bus.tx_done, bus.tx_fail}), 32'b00);
      check({tag, "_send_data"}, 32'({bus.frm_seq, bus.frm_data}), 32'({m_seq, data}));
      exp_q.push_back({m_seq, data});

      // Backpressure; a good-looking ACK here must be ignored.
      for (int b = 0; b < bp; b++) begin
        if (bad) begin
          bus.ack_valid = 1'b1;
          bus.ack_seq   = m_seq;
          bus.ack_err   = 1'b0;
        end
        step();
        bus.ack_valid = 1'b0;
        check({tag, "_bp_hold"}, 32'({bus.frm_valid, bus.frm_seq, bus.frm_data}),
              32'({1'b1, m_seq, data}));
      end

      bus.frm_ready = 1'b1;
      step();
      bus.frm_ready = 1'b0;

      for (int w = 0; w < TIMEOUT && !acked; w++) begin
        check({tag, "_wait"}, 32'({bus.frm_valid, bus.busy}), 32'b01);
        if (ack_at[s] == w) begin
          bus.ack_valid = 1'b1;
          bus.ack_seq   = m_seq;
          bus.ack_err   = 1'b0;
          acked = 1'b1;
        end else if (bad && (w % 4 == 1)) begin
          kind = int'($urandom_range(0, 2));
          bus.ack_valid = 1'b1;
          bus.ack_seq   = (kind == 0) ? m_seq : ~m_seq;
          bus.ack_err   = (kind != 1);
        end
        step();
        bus.ack_valid = 1'b0;
        bus.ack_err   = 1'b0;
        bus.ack_seq   = 1'b0;
      end
    end

    if (exp_done) begin
      m_seq = ~m_seq;
      check({tag, "_done_pulses"}, 32'({bus.tx_done, bus.tx_fail}), 32'b10);
      check({tag, "_done_seq"}, 32'(bus.frm_seq), 32'(m_seq));
      check({tag, "_done_retry"}, 32'(bus.retry_cnt), 32'(exp_sends - 1));
    end else begin
      check({tag, "_fail_pulses"}, 32'({bus.tx_done, bus.tx_fail}), 32'b01);
      check({tag, "_fail_seq"}, 32'(bus.frm_seq), 32'(m_seq));
      check({tag, "_fail_retry"}, 32'(bus.retry_cnt), 32'(MAX_RETRY));
    end
    check({tag, "_end_rdy_busy"}, 32'({bus.pkt_ready, bus.busy}), 32'b10);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rstn          = 1'b0;
    bus.pkt_valid = 1'b0;
    bus.pkt_data  = '0;
    bus.frm_ready = 1'b0;
    bus.ack_valid = 1'b0;
    bus.ack_seq   = 1'b0;
    bus.ack_err   = 1'b0;
    m_seq         = 1'b0;

    // Power-on reset.
    step();
    step();
    check("rst_pkt_ready_low", 32'(bus.pkt_ready), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rstn = 1'b1;
    #1;
    check("rst_pkt_ready_high", 32'(bus.pkt_ready), 32'd1);
    check("rst_outputs", 32'({bus.frm_valid, bus.frm_seq, bus.frm_data, bus.tx_done, bus.tx_fail}), 32'd0);
    check("rst_retry", 32'(bus.retry_cnt), 32'd0);

    // Directed plans: ack position per send, -1 means no ACK for that send.
    vt[0] = '{8'hA5,  0,  5, -1, -1, 1'b0, 1, 1'b1, "happy"};
    vt[1] = '{8'h3C,  0,  2, -1, -1, 1'b0, 1, 1'b1, "seq_one"};
    vt[2] = '{8'h5A,  0, -1,  0, -1, 1'b0, 2, 1'b1, "timeout_resend"};
    vt[3] = '{8'hC3,  0, -1, -1, -1, 1'b0, 3, 1'b0, "abort"};
    vt[4] = '{8'h96,  0, 15, -1, -1, 1'b1, 1, 1'b1, "bad_ack_ack_on_timeout"};
    vt[5] = '{8'h69,  0, -1, 15, -1, 1'b1, 2, 1'b1, "bad_ack_resend"};
    vt[6] = '{8'h0F, 10,  3, -1, -1, 1'b0, 1, 1'b1, "backpressure"};
    vt[7] = '{8'hF0,  2, -1, -1, 15, 1'b1, 3, 1'b1, "last_retry_ack"};
    vt[8] = '{8'h81, 25, -1, -1, -1, 1'b1, 3, 1'b0, "abort_long_bp"};

    for (int i = 0; i < 9; i++) begin
      run_packet(vt[i].data, vt[i].bp, vt[i].a0, vt[i].a1, vt[i].a2,
                 vt[i].bad, vt[i].exp_sends, vt[i].exp_done, vt[i].name);
    end

    // Reset held for 2 cycles in the middle of WAIT.
    bus.pkt_valid = 1'b1;
    bus.pkt_data  = 8'h77;
    step();
    bus.pkt_valid = 1'b0;
    exp_q.push_back({m_seq, 8'h77});
    bus.frm_ready = 1'b1;
    step();
    bus.frm_ready = 1'b0;
    step();
    step();
    step();
    check("t1_pre_busy", 32'({bus.frm_valid, bus.busy}), 32'b01);
    rstn = 1'b0;
    step();
    check("t1_rst_rdy_busy_valid", 32'({bus.pkt_ready, bus.busy, bus.frm_valid}), 32'b000);
    step();
    check("t1_rst_pkt_ready", 32'(bus.pkt_ready), 32'd0);
    check("t1_rst_pulses", 32'({bus.tx_done, bus.tx_fail}), 32'b00);
    rstn = 1'b1;
    #1;
    m_seq = 1'b0;
    check("t1_after_rdy", 32'(bus.pkt_ready), 32'd1);
    check("t1_after_seq_data", 32'({bus.frm_seq, bus.frm_data}), 32'd0);
    check("t1_after_retry_busy", 32'({bus.retry_cnt, bus.busy}), 32'd0);

    // Randomized plans; the outcome comes from the transaction model:
    // the packet completes on the first send that sees an in-window ACK,
    // otherwise it fails after MAX_RETRY+1 sends.
    for (int i = 0; i < 40; i++) begin
      int  a[3];
      int  sends;
      bit  done;
      for (int s = 0; s < 3; s++) begin
        a[s] = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, TIMEOUT - 1));
      end
      done  = 1'b0;
      sends = MAX_RETRY + 1;
      for (int s = 0; s <= MAX_RETRY; s++) begin
        if (!done && a[s] >= 0 && a[s] < TIMEOUT) begin
          done  = 1'b1;
          sends = s + 1;
        end
      end
      run_packet(8'($urandom), int'($urandom_range(0, 20)), a[0], a[1], a[2],
                 1'($urandom_range(0, 1)), sends, done, "rand");
    end

    step();
    check("frames_left_in_queue", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
